// File: rtl/tensor_ctrl_pkg.sv
// Shared types and helpers for the tensor-array control blocks.
// Holds the sequencer state encoding and the pipeline drain-length calculation.
package tensor_ctrl_pkg;

  localparam int K_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } pe_seq_state_t;

  // Cycles from the last activation read until its result leaves the skewed array.
  function automatic int drain_len(input int array_n, input int mem_lat);
    return mem_lat + 2 * array_n - 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable down-counter that saturates at zero and flags terminal count.
// Load/clear take effect on the next edge; no backpressure.
module seq_counter
  import tensor_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/pe_array_seq.sv
// Tile sequencer for a weight-stationary ARRAY_N x ARRAY_N mac_pe array.
// One tile per accepted start; start is ignored while busy, abort returns to IDLE next edge.
module pe_array_seq
  import tensor_ctrl_pkg::*;
#(
  parameter int ARRAY_N = 4,
  parameter int K_W     = K_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [K_W-1:0]             k_len,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [$clog2(ARRAY_N)-1:0] w_rd_addr,
  output logic                       act_rd_en,
  output logic [K_W-1:0]             act_rd_addr,
  output logic                       pe_clear_acc,
  output logic                       pe_load_weight,
  output logic                       pe_enable,
  output logic                       out_valid,
  output logic [K_W-1:0]             out_idx
);

  localparam int AW        = $clog2(ARRAY_N);
  localparam int LW_LEN    = ARRAY_N + MEM_LAT;
  localparam int LW_W      = $clog2(LW_LEN + 1);
  localparam int DRAIN_LEN = drain_len(ARRAY_N, MEM_LAT);
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  pe_seq_state_t  state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] out_idx_q, out_idx_d;
  logic           abort_act;
  logic           lw_load, st_load, dr_load;
  logic [LW_W-1:0] lw_cnt, lw_elapsed;
  logic [K_W-1:0] st_cnt, act_idx;
  logic [DW-1:0]  dr_cnt;
  logic           lw_tc, st_tc, dr_tc;

  assign abort_act = abort && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    lw_load = 1'b0;
    st_load = 1'b0;
    dr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (k_len != '0) begin
            k_len_d = k_len;
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLEAR: begin
        lw_load = 1'b1;
        state_d = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (lw_tc) begin
          st_load = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (st_tc) begin
          dr_load = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dr_tc) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_len_q   <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_len_q   <= k_len_d;
      out_idx_q <= out_idx_d;
    end
  end

  seq_counter #(.W(LW_W)) u_lw_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort_act),
    .load_i     (lw_load),
    .load_val_i (LW_W'(LW_LEN - 1)),
    .dec_i      (state_q == ST_LOAD_W),
    .cnt_o      (lw_cnt),
    .tc_o       (lw_tc)
  );

  seq_counter #(.W(K_W)) u_st_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort_act),
    .load_i     (st_load),
    .load_val_i (k_len_q - K_W'(1)),
    .dec_i      (state_q == ST_STREAM),
    .cnt_o      (st_cnt),
    .tc_o       (st_tc)
  );

  seq_counter #(.W(DW)) u_dr_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort_act),
    .load_i     (dr_load),
    .load_val_i (DW'(DRAIN_LEN - 1)),
    .dec_i      (state_q == ST_DRAIN),
    .cnt_o      (dr_cnt),
    .tc_o       (dr_tc)
  );

  // Read data returns MEM_LAT cycles after the address, so load_weight trails w_rd_en.
  assign lw_elapsed     = LW_W'(LW_LEN - 1) - lw_cnt;
  assign act_idx        = k_len_q - K_W'(1) - st_cnt;

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pe_clear_acc   = (state_q == ST_CLEAR);
  assign w_rd_en        = (state_q == ST_LOAD_W) && (lw_elapsed < LW_W'(ARRAY_N));
  assign w_rd_addr      = w_rd_en ? lw_elapsed[AW-1:0] : '0;
  assign pe_load_weight = (state_q == ST_LOAD_W) && (lw_elapsed >= LW_W'(MEM_LAT));
  assign act_rd_en      = (state_q == ST_STREAM);
  assign act_rd_addr    = act_rd_en ? act_idx : '0;
  assign pe_enable      = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  // Results emerge DRAIN_LEN cycles after their read: the last k_len cycles of STREAM+DRAIN.
  assign out_valid = (act_rd_en && (act_idx >= K_W'(DRAIN_LEN))) ||
                     ((state_q == ST_DRAIN) && (K_W'(dr_cnt) < k_len_q));

  always_comb begin
    out_idx_d = out_idx_q;
    if (abort_act || (state_q == ST_DONE)) begin
      out_idx_d = '0;
    end else if (out_valid) begin
      out_idx_d = out_idx_q + K_W'(1);
    end
  end

  assign out_idx = out_idx_q;

endmodule
